// File: rtl/iob_cache_tg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : iob_cache_tg_pkg
// Description : Shared types and data-pattern functions for the cache traffic
//               generator (optional IOB_TG_PARTIAL_WSTRB_EN merge pattern).
// Revision    : 1.0 - initial release
//==============================================================================
package iob_cache_tg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_WR_GAP = 3'd2,
      ST_RD     = 3'd3,
      ST_RD_GAP = 3'd4,
      ST_DONE   = 3'd5
   } tg_state_t;

   localparam logic [31:0] c_PATTERN    = 32'hDEADBEEF;
   // Functions return the widest supported word; callers size-cast to DATA_W.
   localparam int          c_MAX_DATA_W = 1024;

   function automatic logic [c_MAX_DATA_W-1:0] pattern(input logic [31:0] i);
      return {(c_MAX_DATA_W/32){c_PATTERN}} ^ {{(c_MAX_DATA_W-32){1'b0}}, i};
   endfunction

   // With partial strobes the word holds the inverted pattern except one byte.
   function automatic logic [c_MAX_DATA_W-1:0] expected(input logic [31:0] i,
                                                        input int          n_bytes,
                                                        input bit          partial);
      logic [c_MAX_DATA_W-1:0] p;
      logic [c_MAX_DATA_W-1:0] e;
      p = pattern(i);
      e = p;
      if (partial) begin
         e = ~p;
         for (int b = 0; b < c_MAX_DATA_W/8; b++) begin
            if (b == int'(i % 32'(n_bytes)))
               e[b*8 +: 8] = p[b*8 +: 8];
         end
      end
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cache_traffic_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : iob_cache_traffic_gen_if
// Description : Native cache front-end request/response bundle.
// Revision    : 1.0 - initial release
//==============================================================================
interface iob_cache_traffic_gen_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   localparam int c_WADDR_W = ADDR_W - $clog2(DATA_W/8);

   logic                  valid;
   logic [c_WADDR_W-1:0]  addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;

   modport master (output valid, addr, wdata, wstrb, input  rdata, ready);
   modport slave  (input  valid, addr, wdata, wstrb, output rdata, ready);
endinterface
`default_nettype wire

// File: rtl/iob_cache_tg_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : iob_cache_tg_watchdog
// Description : Counts stalled request cycles; expire fires on the last one.
// Revision    : 1.0 - initial release
//==============================================================================
module iob_cache_tg_watchdog #(
   parameter int TIMEOUT = 256
)(
   input  logic clk,
   input  logic reset,
   input  logic valid,
   input  logic ready,
   output logic expire
);
   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || !valid || ready)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + c_CNT_W'(1);
   end

   // A ready in the final cycle completes the transfer instead of expiring.
   assign expire = valid && !ready && (r_cnt == c_CNT_W'(TIMEOUT - 1));
endmodule
`default_nettype wire

// File: rtl/iob_cache_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : iob_cache_traffic_gen
// Description : Native-port write/read-back traffic generator and checker.
//               Optional macro IOB_TG_PARTIAL_WSTRB_EN adds byte-merge writes.
// Revision    : 1.0 - initial release
//==============================================================================
module iob_cache_traffic_gen
   import iob_cache_tg_pkg::*;
#(
   parameter int   ADDR_W    = 13,
   parameter int   DATA_W    = 32,
   parameter int   N_WORDS   = 16,
   parameter int   BASE_ADDR = 0,
   parameter int   TIMEOUT   = 256,
   parameter int   ERR_W     = 16,
   localparam int  c_WADDR_W = ADDR_W - $clog2(DATA_W/8)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   output logic                  busy,
   output logic                  done,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [c_WADDR_W-1:0]  first_err_addr,
   output logic                  timeout,
   iob_cache_traffic_gen_if.master bus
);
   localparam int c_STRB_W = DATA_W / 8;
   localparam int c_IDX_W  = $clog2(N_WORDS + 1);

   tg_state_t              r_state;
   logic                   r_mode;
   logic [c_IDX_W-1:0]     r_idx;
   logic                   r_busy;
   logic                   r_done;
   logic [ERR_W-1:0]       r_err_cnt;
   logic [c_WADDR_W-1:0]   r_first_err;
   logic                   r_timeout;
   logic                   r_valid;
   logic [c_WADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic [c_STRB_W-1:0]    r_wstrb;

   logic [c_IDX_W-1:0]     w_inc;
   logic                   w_more;
   logic [c_IDX_W-1:0]     w_req_idx;
   logic [c_WADDR_W-1:0]   w_req_addr;
   logic [DATA_W-1:0]      w_req_pat;
   logic [DATA_W-1:0]      w_wr_data;
   logic [DATA_W-1:0]      w_exp;
   logic                   w_expire;
   logic                   w_write_again;
   logic [c_STRB_W-1:0]    w_again_strb;

`ifdef IOB_TG_PARTIAL_WSTRB_EN
   localparam bit c_PARTIAL = 1'b1;
   logic r_half;

   assign w_write_again = !r_half;
   assign w_wr_data     = ~w_req_pat;
   assign w_again_strb  = c_STRB_W'(1) << (32'(r_idx) % 32'(c_STRB_W));

   always_ff @(posedge clk) begin
      if (reset || r_state == ST_IDLE)
         r_half <= 1'b0;
      else if (r_state == ST_WR_GAP)
         r_half <= !r_half;
   end
`else
   localparam bit c_PARTIAL = 1'b0;
   assign w_write_again = 1'b0;
   assign w_wr_data     = w_req_pat;
   assign w_again_strb  = '1;
`endif

   // Index of the request about to be issued from the current state.
   always_comb begin
      w_inc     = r_idx + c_IDX_W'(1);
      w_more    = (w_inc < c_IDX_W'(N_WORDS));
      w_req_idx = '0;
      case (r_state)
         ST_WR_GAP: begin
            if (w_write_again || r_mode) w_req_idx = r_idx;
            else if (w_more)             w_req_idx = w_inc;
         end
         ST_RD_GAP: w_req_idx = w_inc;
         default:   w_req_idx = '0;
      endcase
   end

   assign w_req_addr = c_WADDR_W'(32'(BASE_ADDR) + 32'(w_req_idx));
   assign w_req_pat  = DATA_W'(pattern(32'(w_req_idx)));
   assign w_exp      = DATA_W'(expected(32'(r_idx), c_STRB_W, c_PARTIAL));

   iob_cache_tg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .valid  (r_valid),
      .ready  (bus.ready),
      .expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
         r_timeout   <= 1'b0;
         r_valid     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy      <= 1'b1;
                  r_err_cnt   <= '0;
                  r_first_err <= '0;
                  r_timeout   <= 1'b0;
                  r_mode      <= mode;
                  r_idx       <= '0;
                  r_valid     <= 1'b1;
                  r_addr      <= w_req_addr;
                  r_wdata     <= w_wr_data;
                  r_wstrb     <= '1;
                  r_state     <= ST_WR;
               end
            end
            ST_WR, ST_RD: begin
               if (bus.ready) begin
                  r_valid <= 1'b0;
                  r_state <= (r_state == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
                  if (r_state == ST_RD && bus.rdata != w_exp) begin
                     if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                     if (r_err_cnt == '0) r_first_err <= r_addr;
                  end
               end else if (w_expire) begin
                  r_valid   <= 1'b0;
                  r_timeout <= 1'b1;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_WR_GAP: begin
               r_valid <= 1'b1;
               r_addr  <= w_req_addr;
               if (w_write_again) begin
                  r_wdata <= w_req_pat;
                  r_wstrb <= w_again_strb;
                  r_state <= ST_WR;
               end else if (r_mode || !w_more) begin
                  if (!r_mode) r_idx <= '0;
                  r_wdata <= '0;
                  r_wstrb <= '0;
                  r_state <= ST_RD;
               end else begin
                  r_idx   <= w_inc;
                  r_wdata <= w_wr_data;
                  r_wstrb <= '1;
                  r_state <= ST_WR;
               end
            end
            ST_RD_GAP: begin
               r_idx <= w_inc;
               if (w_more) begin
                  r_valid <= 1'b1;
                  r_addr  <= w_req_addr;
                  if (r_mode) begin
                     r_wdata <= w_wr_data;
                     r_wstrb <= '1;
                     r_state <= ST_WR;
                  end else begin
                     r_wdata <= '0;
                     r_wstrb <= '0;
                     r_state <= ST_RD;
                  end
               end else begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign err_cnt        = r_err_cnt;
   assign first_err_addr = r_first_err;
   assign timeout        = r_timeout;
   assign bus.valid      = r_valid;
   assign bus.addr       = r_addr;
   assign bus.wdata      = r_wdata;
   assign bus.wstrb      = r_wstrb;
endmodule
`default_nettype wire

// File: tb/tb_iob_cache_traffic_gen.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_iob_cache_traffic_gen
// Description : Directed bench: three generators, each on a memory slave model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_iob_cache_traffic_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]       start_v  = '0;
   logic [2:0]       mode_v   = '0;
   logic [2:0]       stall_v  = '0;
   logic [2:0]       bad_en   = '0;
   logic [10:0]      bad_addr = '0;
   logic [2:0]       busy_v, done_v, to_v, valid_v, rd_v;
   logic [2:0][15:0] err_v;
   logic [2:0][10:0] fea_v, addr_v;
   int total = 0;
   int bad   = 0;

   // Instance 0: base 0, instance 1: base 13'h1234, instance 2: top word, 2 words.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      iob_cache_traffic_gen_if #(.ADDR_W(13), .DATA_W(32)) bus ();
      logic [31:0] mem   [2048];
      logic [11:0] log_a [1024];
      int          log_n = 0;

      iob_cache_traffic_gen #(
         .ADDR_W    (13),
         .DATA_W    (32),
         .N_WORDS   (g == 2 ? 2 : 16),
         .BASE_ADDR (g == 0 ? 0 : (g == 1 ? 32'h1234 : 32'h7FF)),
         .TIMEOUT   (8),
         .ERR_W     (16)
      ) u_dut (
         .clk            (clk),
         .reset          (rst),
         .start          (start_v[g]),
         .mode           (mode_v[g]),
         .busy           (busy_v[g]),
         .done           (done_v[g]),
         .err_cnt        (err_v[g]),
         .first_err_addr (fea_v[g]),
         .timeout        (to_v[g]),
         .bus            (bus.master)
      );

      assign bus.ready  = bus.valid & ~stall_v[g];
      assign bus.rdata  = mem[bus.addr] ^
                          {31'b0, bad_en[g] && (bus.addr == bad_addr) && (bus.wstrb == 4'b0)};
      assign valid_v[g] = bus.valid;
      assign rd_v[g]    = bus.valid && (bus.wstrb == 4'b0);
      assign addr_v[g]  = bus.addr;

      always @(posedge clk) begin
         if (bus.valid && bus.ready) begin
            if (log_n < 1024) log_a[log_n] <= {|bus.wstrb, bus.addr};
            log_n <= log_n + 1;
            for (int b = 0; b < 4; b++)
               if (bus.wstrb[b]) mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int g, input logic m, input bit dbl, output int cyc, output int nd);
      @(negedge clk);
      start_v[g] = 1'b1;
      mode_v[g]  = m;
      @(negedge clk);
      start_v[g] = 1'b0;
      cyc = 1;
      nd  = 0;
      if (dbl) begin
         start_v[g] = 1'b1;
         @(negedge clk);
         start_v[g] = 1'b0;
         cyc = 2;
      end
      while (!done_v[g] && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("run_done_seen", {31'b0, done_v[g]}, 32'd1);
      chk("busy_at_done", {31'b0, busy_v[g]}, 32'd0);
      if (done_v[g]) nd = 1;
      repeat (10) begin
         @(negedge clk);
         if (done_v[g]) nd++;
      end
   endtask

   initial begin
      int          cyc;
      int          nd;
      int          vc;
      logic [11:0] e;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",  {31'b0, busy_v[0]},  0);
      chk("rst_done",  {31'b0, done_v[0]},  0);
      chk("rst_valid", {31'b0, valid_v[0]}, 0);
      chk("rst_to",    {31'b0, to_v[0]},    0);
      chk("rst_err",   {16'b0, err_v[0]},   0);
      chk("rst_fea",   {21'b0, fea_v[0]},   0);
      rst = 1'b0;

      // Mode 0, zero-wait, base 0
      run(0, 1'b0, 1'b0, cyc, nd);
      chk("t1_cycles", cyc, 65);
      chk("t1_ndone",  nd, 1);
      chk("t1_err",    {16'b0, err_v[0]}, 0);
      chk("t1_to",     {31'b0, to_v[0]},  0);
      chk("t1_mem3",   g_dut[0].mem[3],  32'hDEADBEEC);
      chk("t1_mem15",  g_dut[0].mem[15], 32'hDEADBEE0);
      chk("t1_logn",   g_dut[0].log_n, 32);
      chk("t1_log0",   {20'b0, g_dut[0].log_a[0]},  32'h800);
      chk("t1_log15",  {20'b0, g_dut[0].log_a[15]}, 32'h80F);
      chk("t1_log16",  {20'b0, g_dut[0].log_a[16]}, 32'h000);

      // Mode 1, base wraps to word 0x234
      run(1, 1'b1, 1'b0, cyc, nd);
      chk("t2_cycles", cyc, 65);
      chk("t2_err",    {16'b0, err_v[1]}, 0);
      chk("t2_logn",   g_dut[1].log_n, 32);
      for (int k = 0; k < 32; k++) begin
         e = {(k % 2) == 0, 11'(32'h234 + k / 2)};
         chk("t2_order", {20'b0, g_dut[1].log_a[k]}, {20'b0, e});
      end
      chk("t2_mem239", g_dut[1].mem[11'h239], 32'hDEADBEEA);

      // Corrupted read of word 5
      bad_en[0] = 1'b1;
      bad_addr  = 11'd5;
      run(0, 1'b0, 1'b0, cyc, nd);
      chk("t3_err", {16'b0, err_v[0]}, 1);
      chk("t3_fea", {21'b0, fea_v[0]}, 5);
      chk("t3_to",  {31'b0, to_v[0]},  0);
      bad_en[0] = 1'b0;

      // Slave never ready: valid for exactly TIMEOUT cycles then abort
      stall_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b1;
      mode_v[0]  = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b0;
      vc  = 0;
      cyc = 1;
      while (!done_v[0] && cyc < 50) begin
         if (valid_v[0]) vc++;
         @(negedge clk);
         cyc++;
      end
      chk("t4_done",   {31'b0, done_v[0]},  1);
      chk("t4_vcyc",   vc, 8);
      chk("t4_to",     {31'b0, to_v[0]},    1);
      chk("t4_busy",   {31'b0, busy_v[0]},  0);
      chk("t4_valid",  {31'b0, valid_v[0]}, 0);
      chk("t4_errclr", {16'b0, err_v[0]},   0);
      @(negedge clk);
      chk("t4_done_1cyc", {31'b0, done_v[0]}, 0);
      stall_v[0] = 1'b0;

      // Reset during the 7th read, then a clean run
      bad_en[0] = 1'b1;
      bad_addr  = 11'd2;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      cyc = 1;
      while (!(rd_v[0] && addr_v[0] == 11'd6) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("t5_at_rd6", {31'b0, rd_v[0] && addr_v[0] == 11'd6}, 1);
      chk("t5_err_pre", {16'b0, err_v[0]}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_valid", {31'b0, valid_v[0]}, 0);
      chk("t5_busy",  {31'b0, busy_v[0]},  0);
      chk("t5_done",  {31'b0, done_v[0]},  0);
      chk("t5_err",   {16'b0, err_v[0]},   0);
      chk("t5_fea",   {21'b0, fea_v[0]},   0);
      chk("t5_to",    {31'b0, to_v[0]},    0);
      repeat (2) @(negedge clk);
      chk("t5_no_done", {31'b0, done_v[0]}, 0);
      rst       = 1'b0;
      bad_en[0] = 1'b0;
      run(0, 1'b0, 1'b0, cyc, nd);
      chk("t5_rerun_cycles", cyc, 65);
      chk("t5_rerun_err",    {16'b0, err_v[0]}, 0);
      chk("t5_rerun_to",     {31'b0, to_v[0]},  0);

      // Top word base, two words, second start while busy
      run(2, 1'b0, 1'b1, cyc, nd);
      chk("t6_cycles", cyc, 9);
      chk("t6_ndone",  nd, 1);
      chk("t6_err",    {16'b0, err_v[2]}, 0);
      chk("t6_logn",   g_dut[2].log_n, 4);
      chk("t6_log0",   {20'b0, g_dut[2].log_a[0]}, 32'hFFF);
      chk("t6_log1",   {20'b0, g_dut[2].log_a[1]}, 32'h800);
      chk("t6_log3",   {20'b0, g_dut[2].log_a[3]}, 32'h000);
      chk("t6_mem_top", g_dut[2].mem[11'h7FF], 32'hDEADBEEF);
      chk("t6_mem0",    g_dut[2].mem[0],       32'hDEADBEEE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/iob_cache_traffic_gen.md
Name: iob_cache_traffic_gen

Overview:
- Synthesizable, parametrised native-interface traffic generator and checker; drives a cache front-end (iob_cache) as its master.
- Replaces hand-written stimulus with an FSM that:
  - writes a programmable block of words with a deterministic pattern;
  - reads the block back and compares;
  - counts mismatches and handshake timeouts.
- Used in cache benches and on-FPGA self-test; sits directly on the cache's valid/addr/wdata/wstrb/rdata/ready port.

Parameters:
- ADDR_W, 13, byte-address width of the cache front-end.
- DATA_W, 32, data word width; must be a multiple of 32.
- N_WORDS, 16, number of words in the test block; range 1..2**(ADDR_W-$clog2(DATA_W/8)).
- BASE_ADDR, 0, first word address of the block; wraps modulo the word-address space.
- TIMEOUT, 256, maximum cycles valid may stay high without ready.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- mode  in  1  0 = write-all-then-read-all, 1 = interleaved write/read per word; latched at start
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run ends
- err_cnt  out  ERR_W  saturating data-mismatch count for the last run
- first_err_addr  out  ADDR_W-$clog2(DATA_W/8)  word address of the first mismatch
- timeout  out  1  sticky: the run aborted on a handshake timeout
- valid  out  1  native request valid
- addr  out  ADDR_W-$clog2(DATA_W/8)  native word address
- wdata  out  DATA_W  native write data
- wstrb  out  DATA_W/8  native byte strobes; all-ones = write, zero = read
- rdata  in  DATA_W  native read data, sampled in the cycle ready is high
- ready  in  1  native transfer acknowledge

Behaviour:
- Reset values:
  - all outputs 0; FSM in IDLE.
  - Reset mid-run abandons the run immediately. valid drops in the cycle after reset is sampled. No done pulse.
- Pattern:
  - word index i maps to address (BASE_ADDR+i) mod 2**(ADDR_W-$clog2(DATA_W/8)).
  - Write data is {DATA_W/32{32'hDEADBEEF}} XOR zero-extended i.
- Handshake:
  - valid, addr, wdata and wstrb are registered. They stay stable from assertion until the cycle ready is sampled high.
  - valid deasserts in the following cycle and stays low for at least one cycle between requests.
  - ready while valid is low is ignored.
- FSM states: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE:
  - start is accepted only here. Accepting it clears err_cnt, first_err_addr and timeout, latches mode, sets busy, sets i=0 and enters WR.
  - start while busy is ignored.
- WR: valid=1, wstrb=all-ones. On ready, go to WR_GAP.
- WR_GAP:
  - mode 0: i++; go to WR if i<N_WORDS, else reset i=0 and go to RD.
  - mode 1: go to RD for the same i.
- RD:
  - valid=1, wstrb=0.
  - On ready, compare rdata with the pattern for i.
  - On mismatch, err_cnt increments, saturating at all-ones. first_err_addr is loaded only if err_cnt was 0.
  - Go to RD_GAP.
- RD_GAP:
  - i++.
  - If i<N_WORDS: mode 0 goes to RD, mode 1 goes to WR.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Timeout:
  - A cycle counter runs while valid=1 and ready=0.
  - When it reaches TIMEOUT-1 with ready still low: set timeout, drop valid, go to DONE.
  - ready arriving in that same cycle wins, and no timeout is flagged.
- Latency: minimum 2 cycles per transfer (request cycle plus gap). A zero-wait slave completes N_WORDS write+read in 4*N_WORDS+2 cycles from start.
- N_WORDS=1 is a legal boundary case.
- Address wrap past the top of the word space is modulo; no error is raised.

Optional Feature:
- Macro IOB_TG_PARTIAL_WSTRB_EN.
- Defined:
  - The WR phase writes each word twice. First, full strobes with the inverted pattern. Second, wstrb = one-hot byte (i mod DATA_W/8) carrying the true pattern byte.
  - The read compare uses the expected merge: inverted pattern everywhere except the selected byte.
  - This exercises cache byte-merge.
- Undefined: one full-strobe write per word, as above; no extra states or logic.

Decomposition:
- Package iob_cache_tg_pkg holds:
  - FSM state enum;
  - pattern constant 32'hDEADBEEF;
  - function pattern(i) returning DATA_W bits;
  - function expected(i), which also covers the partial-strobe variant.
- One sub-module is natural: iob_cache_tg_watchdog. It holds the timeout counter with inputs clk, reset, valid, ready and output expire.

Test Plan:
- Zero-wait memory (mem_ready<=mem_valid behind iob_cache), N_WORDS=16, mode 0, BASE_ADDR=0 -> done after the run, err_cnt=0, timeout=0, and word 3 of memory holds 32'hDEADBEEC.
- Same setup, mode 1, BASE_ADDR=13'h1234 word offset -> alternating write/read of each address, err_cnt=0.
- Bench slave corrupts rdata bit 0 on word index 5 -> err_cnt=1, first_err_addr=BASE_ADDR+5.
- Slave never asserts ready, TIMEOUT=8 -> valid high exactly 8 cycles, then timeout=1, done pulse, busy=0.
- Reset asserted during the 7th read -> valid low in the next cycle, all outputs 0. A fresh start then completes with err_cnt=0.
- BASE_ADDR=top word address, N_WORDS=2 -> second access goes to word address 0; start pulsed while busy is ignored (single done pulse).
